// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the packet-locking weighted round-robin arbiter.
package arbiter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Index width for N requesters, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [31:0] weight_eff(input logic [31:0] w);
        return (w == '0) ? 32'd1 : w;
    endfunction

endpackage

// File: rtl/arbiter_wrr_pkt_if.sv
// Requester-side and sink-side handshake bundle of the arbiter.
interface arbiter_wrr_pkt_if #(
    parameter int N      = 4,
    parameter int DWIDTH = 20,
    parameter int WWIDTH = 4
);
    localparam int IW = arbiter_pkg::idx_width(N);

    logic [N-1:0]              in_valid;
    logic [N-1:0][DWIDTH-1:0]  in_data;
    logic [N-1:0]              in_last;
    logic [N-1:0]              in_ready;
    logic [N-1:0][WWIDTH-1:0]  weight;
    logic                      out_valid;
    logic [DWIDTH-1:0]         out_data;
    logic                      out_last;
    logic                      out_ready;
    logic [IW-1:0]             grant_id;

    modport slave (
        input  in_valid, in_data, in_last, weight, out_ready,
        output in_ready, out_valid, out_data, out_last, grant_id
    );

    modport master (
        output in_valid, in_data, in_last, weight, out_ready,
        input  in_ready, out_valid, out_data, out_last, grant_id
    );

endinterface

// File: rtl/arbiter_rr_pick.sv
// Combinational round-robin search: first requester at or after ptr, modulo N.
module arbiter_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);
    logic [2*N-1:0] req2;
    logic [N-1:0]   rot;
    logic [IW:0]    sum;

    // Doubling the vector makes the rotate valid for non-power-of-2 N.
    always_comb begin
        req2    = {req_i, req_i};
        rot     = req2[ptr_i +: N];
        found_o = 1'b0;
        idx_o   = '0;
        sum     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!found_o && rot[k]) begin
                found_o = 1'b1;
                sum     = (IW+1)'(ptr_i) + (IW+1)'(k);
                idx_o   = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
            end
        end
    end

endmodule

// File: rtl/arbiter_wrr_pkt.sv
// N-input weighted round-robin arbiter that holds a grant for whole packets,
// with a single registered output stage.
module arbiter_wrr_pkt
    import arbiter_pkg::*;
#(
    parameter int N      = 4,
    parameter int DWIDTH = 20,
    parameter int WWIDTH = 4
) (
    input logic               clk,
    input logic               rst,
    arbiter_wrr_pkt_if.slave  bus
);
    localparam int IW = idx_width(N);

    arb_state_t        state_q;
    logic [IW-1:0]     ptr_q;
    logic [IW-1:0]     grant_q;
    logic [WWIDTH-1:0] credit_q;
    logic              boundary_q;
    logic              out_valid_q;
    logic              out_last_q;
    logic [DWIDTH-1:0] out_data_q;

    logic [N-1:0]      in_ready_c;
    logic              pick_found;
    logic [IW-1:0]     pick_idx;
    logic [IW-1:0]     ptr_wrap;
    logic              out_free;
    logic              cur_valid;
    logic              cur_last;
    logic              accept;

    arbiter_rr_pick #(.N(N), .IW(IW)) u_pick (
        .req_i   (bus.in_valid),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign out_free  = !out_valid_q || bus.out_ready;
    assign cur_valid = bus.in_valid[grant_q];
    assign cur_last  = bus.in_last[grant_q];
    assign accept    = (state_q == LOCKED) && cur_valid && out_free;
    assign ptr_wrap  = (grant_q == IW'(N-1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        in_ready_c = '0;
        if (state_q == LOCKED) begin
            in_ready_c[grant_q] = out_free;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            credit_q    <= '0;
            boundary_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= bus.in_data[grant_q];
                out_last_q  <= cur_last;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            unique case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        state_q    <= LOCKED;
                        grant_q    <= pick_idx;
                        credit_q   <= WWIDTH'(weight_eff(32'(bus.weight[pick_idx])));
                        boundary_q <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (accept) begin
                        boundary_q <= cur_last;
                        if (cur_last) begin
                            credit_q <= credit_q - 1'b1;
                            if (credit_q == WWIDTH'(1)) begin
                                state_q <= IDLE;
                                ptr_q   <= ptr_wrap;
                            end
                        end
                    end else if (boundary_q && !cur_valid) begin
                        // Idle at a packet boundary gives up the remaining credit.
                        state_q  <= IDLE;
                        ptr_q    <= ptr_wrap;
                        credit_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.grant_id  = grant_q;

endmodule

// File: tb/tb_arbiter_wrr_pkt.sv
// Scoreboard bench: randomized packet sources, a packet-level arbitration model
// that predicts in_ready and the output beat stream, and an N=3 async-reset test.
module tb_arbiter_wrr_pkt;
    localparam int N  = 4;
    localparam int DW = 20;
    localparam int WW = 4;

    logic clk = 1'b0;
    logic rst;
    logic rst3;
    always #5 clk = ~clk;

    arbiter_wrr_pkt_if #(.N(N), .DWIDTH(DW), .WWIDTH(WW)) bus ();
    arbiter_wrr_pkt_if #(.N(3), .DWIDTH(DW), .WWIDTH(WW)) bus3 ();

    arbiter_wrr_pkt #(.N(N), .DWIDTH(DW), .WWIDTH(WW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    arbiter_wrr_pkt #(.N(3), .DWIDTH(DW), .WWIDTH(WW)) dut3 (
        .clk(clk), .rst(rst3), .bus(bus3)
    );

    int errors = 0;
    int checks = 0;
    logic [DW:0] sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the output, how many packets remain, whether
    // the owner is mid-packet, and whether a beat sits in the output slot.
    bit model_en = 0;
    int m_owner  = -1;
    int m_ptr    = 0;
    int m_cred   = 0;
    bit m_mid    = 0;
    bit m_ov     = 0;

    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        bit take, got_one;
        int j;
        if (model_en) begin
            exp_rdy = '0;
            take = 0;
            if (m_owner >= 0 && (!m_ov || bus.out_ready)) exp_rdy[m_owner] = 1'b1;
            check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
            if (m_owner >= 0) begin
                check("grant_id", 32'(bus.grant_id), 32'(m_owner));
                take = bus.in_valid[m_owner] && exp_rdy[m_owner];
            end
            if (take) sb.push_back({bus.in_last[m_owner], bus.in_data[m_owner]});
            if (take) m_ov = 1;
            else if (m_ov && bus.out_ready) m_ov = 0;

            if (m_owner < 0) begin
                got_one = 0;
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr + k) % N;
                    if (!got_one && bus.in_valid[j]) begin
                        got_one = 1;
                        m_owner = j;
                        m_cred  = (bus.weight[j] == 0) ? 1 : int'(bus.weight[j]);
                        m_mid   = 0;
                    end
                end
            end else if (take) begin
                m_mid = !bus.in_last[m_owner];
                if (bus.in_last[m_owner]) begin
                    m_cred--;
                    if (m_cred == 0) begin
                        m_ptr   = (m_owner + 1) % N;
                        m_owner = -1;
                    end
                end
            end else if (!m_mid && !bus.in_valid[m_owner]) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
    end

    // Monitor: pops the scoreboard on each output handshake, checks stall hold.
    bit mon_en = 0;
    bit hold_prev = 0;
    logic [DW:0] prev_beat;

    always @(negedge clk) begin
        logic [DW:0] got, exp;
        if (mon_en) begin
            got = {bus.out_last, bus.out_data};
            if (hold_prev) begin
                check("stall_valid", 32'(bus.out_valid), 32'd1);
                check("stall_hold", 32'(got), 32'(prev_beat));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %0h expected none", got);
                end else begin
                    exp = sb.pop_front();
                    check("beat", 32'(got), 32'(exp));
                end
            end
            hold_prev = bus.out_valid && !bus.out_ready;
            prev_beat = got;
        end
    end

    // Source configuration and per-input progress.
    int pkts_left[N];
    int len_min[N];
    int len_max[N];
    int stall_at[N];
    int stall_cnt[N];
    int cur_len[N];
    int cur_beat[N];
    int seq[N];
    logic [WW-1:0] w_cfg[N];
    int gap_pct = 0;
    int ordy_pct = 100;
    int stall_len = 0;
    int hold_at = -100;

    task automatic set_all(input int pk, input int lmin, input int lmax, input int w);
        for (int i = 0; i < N; i++) begin
            pkts_left[i] = pk;
            len_min[i]   = lmin;
            len_max[i]   = lmax;
            stall_at[i]  = -1;
            w_cfg[i]     = WW'(w);
        end
        gap_pct = 0; ordy_pct = 100; stall_len = 0; hold_at = -100;
    endtask

    task automatic drive(input int cyc);
        bit v;
        for (int i = 0; i < N; i++) begin
            v = (pkts_left[i] > 0) && ($urandom_range(99) >= gap_pct);
            if (pkts_left[i] > 0 && cur_beat[i] == stall_at[i] && stall_cnt[i] < stall_len) begin
                v = 0;
                stall_cnt[i]++;
            end
            bus.in_valid[i] = v;
            bus.in_data[i]  = {2'(i), 10'(seq[i]), 8'(cur_beat[i])};
            bus.in_last[i]  = (cur_beat[i] == cur_len[i] - 1);
            bus.weight[i]   = w_cfg[i];
        end
        if (cyc >= hold_at && cyc < hold_at + 5) bus.out_ready = 1'b0;
        else bus.out_ready = ($urandom_range(99) < ordy_pct);
    endtask

    task automatic run_phase(input string name, input int budget);
        bit done;
        logic [N-1:0] hs;
        done = 0;
        for (int i = 0; i < N; i++) begin
            cur_beat[i]  = 0;
            stall_cnt[i] = 0;
            cur_len[i]   = $urandom_range(len_max[i], len_min[i]);
        end
        for (int cyc = 0; cyc < budget && !done; cyc++) begin
            @(negedge clk);
            hs = bus.in_valid & bus.in_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i]) begin
                    if (cur_beat[i] == cur_len[i] - 1) begin
                        pkts_left[i]--;
                        seq[i]++;
                        cur_beat[i]  = 0;
                        stall_cnt[i] = 0;
                        cur_len[i]   = $urandom_range(len_max[i], len_min[i]);
                    end else begin
                        cur_beat[i]++;
                    end
                end
            end
            drive(cyc);
            done = (sb.size() == 0) && !bus.out_valid;
            for (int i = 0; i < N; i++) if (pkts_left[i] != 0) done = 0;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s: got busy expected drained", name);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got_n;
        rst = 1'b0;
        rst3 = 1'b0;
        bus.in_valid = '0; bus.in_data = '0; bus.in_last = '0; bus.weight = '0; bus.out_ready = 1'b0;
        bus3.in_valid = '0; bus3.in_last = '0; bus3.weight = '0; bus3.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) bus3.in_data[i] = DW'(i);
        for (int i = 0; i < N; i++) seq[i] = 0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_grant_id", 32'(bus.grant_id), 32'd0);
        rst = 1'b1;
        rst3 = 1'b1;
        model_en = 1;
        mon_en = 1;

        // N=3: lock input 2 mid-packet, then reset asynchronously.
        bus3.in_valid = 3'b100;
        got_n = 0;
        for (int c = 0; c < 20 && !bus3.in_ready[2]; c++) @(negedge clk);
        check("n3_locked2", 32'(bus3.grant_id), 32'd2);
        bus3.in_valid = 3'b111;
        repeat (3) @(negedge clk);
        check("n3_pre_valid", 32'(bus3.out_valid), 32'd1);
        #2 rst3 = 1'b0;
        #1;
        check("n3_async_out_valid", 32'(bus3.out_valid), 32'd0);
        check("n3_async_in_ready", 32'(bus3.in_ready), 32'd0);
        check("n3_async_grant_id", 32'(bus3.grant_id), 32'd0);
        @(negedge clk);
        bus3.in_last = 3'b111;
        rst3 = 1'b1;
        for (int c = 0; c < 40 && got_n < 5; c++) begin
            @(negedge clk);
            if (bus3.out_valid && bus3.out_ready) begin
                check("n3_order", 32'(bus3.out_data), 32'(got_n % 3));
                got_n++;
            end
        end
        if (got_n < 5) begin
            checks++;
            errors++;
            $display("FAIL n3_timeout: got %0d beats expected 5", got_n);
        end
        bus3.in_valid = '0;

        set_all(6, 1, 1, 1);
        run_phase("rr_single", 2000);

        set_all(6, 2, 2, 1);
        w_cfg[0] = 4'd3;
        hold_at = 12;
        run_phase("weights_3111", 2000);

        set_all(0, 1, 1, 1);
        pkts_left[0] = 8;
        pkts_left[2] = 2;
        len_min[2] = 4; len_max[2] = 4;
        stall_at[2] = 2;
        stall_len = 3;
        run_phase("stall_lock", 2000);

        set_all(0, 1, 2, 1);
        pkts_left[0] = 3;
        pkts_left[1] = 1;
        w_cfg[1] = 4'd4;
        run_phase("idle_release", 2000);

        for (int r = 0; r < 4; r++) begin
            set_all(0, 1, 4, 1);
            for (int i = 0; i < N; i++) begin
                pkts_left[i] = $urandom_range(10, 5);
                w_cfg[i]     = WW'($urandom_range(15, 0));
                stall_at[i]  = ($urandom_range(1) == 1) ? 1 : -1;
            end
            stall_len = 2;
            gap_pct   = 30;
            ordy_pct  = 70;
            hold_at   = 20;
            run_phase("random", 5000);
        end

        repeat (4) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arbiter_wrr_pkt.md
Name: arbiter_wrr_pkt

Overview:
- N-input weighted round-robin arbiter with packet lock, valid/ready on every port.
- Once granted, an input keeps the output until `weight` packets (delimited by `in_last`) have passed or it goes idle at a packet boundary.
- Output is registered (one pipeline stage).
- Sits in front of shared packet sinks (NoC links, shared memory ports) where beats of different packets must not interleave.

Parameters:
- N, 4, number of requesters (≥2).
- DWIDTH, 20, payload width.
- WWIDTH, 4, weight width; weight range 1..2^WWIDTH-1, 0 treated as 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  [N]  requester beat valid.
- in_data  in  [N][DWIDTH]  requester payload.
- in_last  in  [N]  final beat of packet.
- in_ready  out  [N]  beat accepted when in_valid&in_ready.
- weight  in  [N][WWIDTH]  packets per grant, per requester.
- out_valid  out  1  output beat valid.
- out_data  out  [DWIDTH]  output payload.
- out_last  out  1  output final beat.
- out_ready  in  1  downstream ready.
- grant_id  out  [$clog2(N)]  index of currently/last granted requester.

Behaviour:
- Reset (rst=0, async) clears:
  - state=IDLE, ptr=0, grant_id=0, credit=0, boundary=1.
  - out_valid=0, out_data=0, out_last=0, in_ready=all 0.
- Reset mid-packet truncates the packet. No recovery or flush; the upstream is reset together with this block.
- States:
  - IDLE: no grant.
  - LOCKED: grant_id owns the output.
- IDLE:
  - Pick the first index i with in_valid[i]=1, searching ptr, ptr+1, … modulo N.
  - If found, at the next edge: state=LOCKED, grant_id=i, credit=max(weight[i],1), boundary=1.
  - If none found, stay in IDLE.
  - in_ready=0 throughout IDLE, so there is exactly one bubble cycle per grant change.
- LOCKED:
  - in_ready[grant_id] = !out_valid | out_ready. All other in_ready=0.
  - An accepted beat loads out_data/out_last and sets out_valid=1 at the next edge. Latency is 1 cycle.
  - If out_valid & out_ready and no new beat is accepted, out_valid clears.
  - Full throughput of 1 beat/cycle while the granted input streams and out_ready=1.
  - On every accepted beat: boundary=in_last[grant_id].
  - On an accepted beat with in_last=1: credit=credit-1.
    - If credit reaches 0: state=IDLE, ptr=(grant_id+1) mod N.
  - If boundary=1 and in_valid[grant_id]=0 in a cycle: release at that edge. state=IDLE, ptr=(grant_id+1) mod N, remaining credit discarded.
  - Never release when boundary=0, i.e. mid-packet. Stalls of in_valid mid-packet keep the lock indefinitely; there is no timeout.
- weight is sampled only at grant time; changes during LOCKED are ignored.
- grant_id holds its last value in IDLE.
- Single-beat packets (in_valid with in_last=1) are legal.
- in_valid deassertion mid-packet is legal and just stalls.
- Output must hold stable while out_valid=1 and out_ready=0 (AXI-stream rule).
- Counter widths:
  - credit is WWIDTH bits and never underflows.
  - ptr is $clog2(N) bits with explicit modulo-N wrap, correct for non-power-of-2 N.

Decomposition:
- arbiter_pkg holds:
  - state enum arb_state_t {IDLE, LOCKED}.
  - function weight_eff (0→1).
  - localparam helper for index width, $clog2(N) with minimum 1.
- One sub-module: arbiter_rr_pick, combinational.
  - Inputs: req[N], ptr.
  - Outputs: found, idx.
  - Implements the rotate / find-first / unrotate search.
- All state, credit and output register live in arbiter_wrr_pkt.

Test Plan:
- Reset, then all inputs valid with 1-beat packets, weights=1, out_ready=1 → grant order 0,1,2,3,0…; each beat appears 1 cycle after acceptance; one bubble per grant change.
- Weights {3,1,1,1}, all inputs streaming 2-beat packets → input 0 sends 3 packets (6 beats) consecutively, then 1 packet each from 1,2,3; no interleaving within packets.
- Input 2 sends a 4-beat packet with in_valid dropped for 3 cycles after beat 2; input 0 valid throughout → lock held, out_data shows beats 2.0–2.3 contiguously, input 0 granted only after 2.3.
- Weight[1]=4 and input 1 goes idle after 1 packet → released at the boundary cycle, ptr=2, next grant to the first valid index at or after 2 (wrap to 0 if 2,3 idle).
- out_ready held 0 for 5 cycles mid-packet → out_valid/out_data/out_last stable, in_ready[grant]=0, no beat lost or duplicated on resume.
- rst asserted (driven 0) asynchronously mid-packet on N=3 instance → out_valid, in_ready and grant_id go 0 immediately (no clock edge needed); after release, arbitration restarts from ptr=0; wrap 2→0 is correct.
